pal_reg: RTL

- Parametrised, field-programmable registered PAL: an N_IN-input, N_OUT-output AND-OR array with N_PT product terms per output.
- Each output has a programmable polarity and a registered/combinational select. Registered outputs feed back into the array.
- The fuse map loads serially at run time, so one instance can realise any small combinational or sequential function (counters, small FSMs) in the PLD area of the design.

---
 rtl/pal_pkg.sv | 17 +
 rtl/pal_macrocell.sv | 48 ++++
 rtl/pal_reg.sv | 74 +++++++
 3 files changed

// File: rtl/pal_pkg.sv
// pal_pkg: shared state encoding, fuse-map geometry helpers and config-bit offsets for pal_reg.
package pal_pkg;
  typedef enum logic [1:0] {UNPROG, LOAD, RUN} state_e;
  localparam int REG_EN_OFS = 0;
  localparam int INV_OFS = 1;
  function automatic int term_len(input int n_in, input int n_out);
    return 2 * (n_in + n_out);
  endfunction
  function automatic int cell_width(input int n_in, input int n_out, input int n_pt);
    return n_pt * term_len(n_in, n_out) + 2;
  endfunction
  // Config bits sit at t=N_PT, so fuse_idx(o, N_PT, *_OFS) addresses them too.
  function automatic int fuse_idx(input int o, input int t, input int k,
                                  input int n_in = 3, input int n_out = 3, input int n_pt = 3);
    return o * cell_width(n_in, n_out, n_pt) + t * term_len(n_in, n_out) + k;
  endfunction
endpackage

// File: rtl/pal_macrocell.sv
// pal_macrocell: one output's AND-OR plane, polarity, feedback register and output mux.
module pal_macrocell
  import pal_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_OUT = 3,
  parameter int N_PT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [cell_width(N_IN, N_OUT, N_PT)-1:0] fuse_i,
  input  logic [N_IN-1:0] in_i,
  input  logic [N_OUT-1:0] fb_i,
  input  logic run_i,
  input  logic en_i,
  input  logic ce_i,
  output logic q_o,
  output logic out_o
);
  localparam int L = term_len(N_IN, N_OUT);
  localparam int REG_EN = fuse_idx(0, N_PT, REG_EN_OFS, N_IN, N_OUT, N_PT);
  localparam int INV = fuse_idx(0, N_PT, INV_OFS, N_IN, N_OUT, N_PT);
  logic [N_IN+N_OUT-1:0] sig;
  logic [L-1:0] lit, m;
  logic [N_PT-1:0] term;
  logic pre, q_q;
  assign sig = {fb_i, in_i};
  // An empty term reads 0, so a term needs at least one fuse plus all connected literals true.
  always_comb begin
    lit = '0;
    m = '0;
    term = '0;
    for (int j = 0; j < N_IN + N_OUT; j++) begin
      lit[2*j] = sig[j];
      lit[2*j+1] = ~sig[j];
    end
    for (int t = 0; t < N_PT; t++) begin
      m = fuse_i[t*L +: L];
      term[t] = (|m) & (&(lit | ~m));
    end
  end
  assign pre = (|term) ^ fuse_i[INV];
  always_ff @(posedge clk)
    if (rst || !run_i) q_q <= 1'b0;
    else if (ce_i) q_q <= pre;
  assign q_o = q_q;
  assign out_o = en_i ? (fuse_i[REG_EN] ? q_q : pre) : 1'b0;
endmodule

// File: rtl/pal_reg.sv
// pal_reg: serially programmed registered PAL; holds the load FSM, fuse store and macrocell array.
module pal_reg
  import pal_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_OUT = 3,
  parameter int N_PT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_IN-1:0] in,
  input  logic ce,
  input  logic prog_start,
  input  logic prog_valid,
  input  logic prog_bit,
  output logic [N_OUT-1:0] out,
  output logic prog_busy,
  output logic prog_done,
  output logic programmed
);
  localparam int CW = cell_width(N_IN, N_OUT, N_PT);
  localparam int FUSES = N_OUT * CW;
  localparam int CNTW = $clog2(FUSES + 1);
  state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [FUSES-1:0] fuse_q, fuse_d;
  logic done_q, done_d;
  logic [N_OUT-1:0] q;
  // prog_start dominates every state and discards any bit presented with it.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fuse_d = fuse_q;
    done_d = 1'b0;
    if (prog_start) begin
      state_d = LOAD;
      cnt_d = '0;
    end else if (state_q == LOAD && prog_valid) begin
      fuse_d[cnt_q] = prog_bit;
      cnt_d = cnt_q + CNTW'(1);
      state_d = (cnt_q == CNTW'(FUSES - 1)) ? RUN : LOAD;
      done_d = (cnt_q == CNTW'(FUSES - 1));
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= UNPROG;
      cnt_q <= '0;
      fuse_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fuse_q <= fuse_d;
      done_q <= done_d;
    end
  for (genvar o = 0; o < N_OUT; o++) begin : g_mc
    pal_macrocell #(.N_IN(N_IN), .N_OUT(N_OUT), .N_PT(N_PT)) u_mc (
      .clk(clk),
      .rst(rst),
      .fuse_i(fuse_q[o*CW +: CW]),
      .in_i(in),
      .fb_i(q),
      .run_i(state_q == RUN && !prog_start),
      .en_i(state_q == RUN),
      .ce_i(ce),
      .q_o(q[o]),
      .out_o(out[o])
    );
  end
  assign prog_busy = (state_q == LOAD);
  assign programmed = (state_q == RUN);
  assign prog_done = done_q;
endmodule
